// File: rtl/fp_pkg.sv
// Shared FP32 constants, arbiter state encoding and operand helpers
// for the shared add/sub unit arbiter.
package fp_pkg;

  localparam int FP32_W     = 32;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_SIGN  = FP32_EXP_W + FP32_MAN_W;

  localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_CLEAR
  } state_t;

  // Subtraction becomes addition of B with its sign inverted.
  function automatic logic [FP32_W-1:0] flip_sign(
    input logic [FP32_W-1:0] b,
    input logic              sub
  );
    return {b[FP32_SIGN] ^ sub, b[FP32_SIGN-1:0]};
  endfunction

endpackage

// File: rtl/fp_addsub_arbiter_if.sv
// Requester-side bundle of the shared FP add/sub arbiter:
// request handshake in, one-hot response pulse out.
interface fp_addsub_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    req_sub;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [31:0]           resp_data;
  logic                  resp_err;

  modport master (
    output req_valid, req_a, req_b, req_sub,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/fp_addsub_arbiter_rr.sv
// Combinational round-robin picker: first set request at or
// above ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [IW-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = IW'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Time-shares one multi-cycle FP32 add/sub unit among NUM_REQ
// requesters with round-robin grant, timeout and done clearing.
module fp_addsub_arbiter
  import fp_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  fp_addsub_arbiter_if.slave bus,
  output logic               busy,
  output logic [FP32_W-1:0]  fu_a1,
  output logic [FP32_W-1:0]  fu_a2,
  output logic               fu_start,
  output logic               fu_reset,
  input  logic [FP32_W-1:0]  fu_result,
  input  logic               fu_done
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t              state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       gnt_idx;
  logic [CW-1:0]       cnt;
  logic                err;
  logic [FP32_W-1:0]   op_a;
  logic [FP32_W-1:0]   op_b;

  logic [NUM_REQ-1:0]  pick;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic [FP32_W-1:0]   sel_a;
  logic [FP32_W-1:0]   sel_b;
  logic                sel_sub;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (pick),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_a   = bus.req_a[32*i +: 32];
        sel_b   = bus.req_b[32*i +: 32];
        sel_sub = bus.req_sub[i];
      end
    end
  end

  // Accept is same-cycle so operands are captured on the transfer edge.
  assign bus.req_ready = (state == S_IDLE && !reset) ? pick : '0;
  assign busy          = (state != S_IDLE);
  assign fu_reset      = reset | (state == S_CLEAR);
  assign fu_a1         = op_a;
  assign fu_a2         = op_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      gnt_idx        <= '0;
      cnt            <= '0;
      err            <= 1'b0;
      op_a           <= '0;
      op_b           <= '0;
      fu_start       <= 1'b0;
      bus.resp_valid <= '0;
      bus.resp_data  <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      fu_start       <= 1'b0;
      bus.resp_valid <= '0;
      unique case (state)
        S_IDLE: begin
          if (pick_any) begin
            gnt_idx  <= pick_idx;
            op_a     <= sel_a;
            op_b     <= flip_sign(sel_b, sel_sub);
            rr_ptr   <= (pick_idx == IW'(NUM_REQ - 1)) ?
                        '0 : pick_idx + 1'b1;
            fu_start <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt   <= '0;
          err   <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (fu_done) begin
            err   <= 1'b0;
            state <= S_CAPTURE;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            err   <= 1'b1;
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          bus.resp_data  <= err ? FP32_QNAN : fu_result;
          bus.resp_err   <= err;
          bus.resp_valid <= NUM_REQ'(1) << gnt_idx;
          state          <= S_CLEAR;
        end
        S_CLEAR: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
